life_step: RTL and testbench

LIFE_STEP -- requirements
Module: life_step

---
 rtl/life_pkg.sv | 24 ++
 rtl/life_row_next.sv | 35 +++
 rtl/life_step.sv | 179 +++++++++++++++++
 tb/tb_life_step.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and rule constants for the Game of Life step engine.
package life_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int NBR_CNT_W = 4;

  localparam logic [NBR_CNT_W-1:0] BIRTH_CNT   = 4'd3;
  localparam logic [NBR_CNT_W-1:0] SURVIVE_MIN = 4'd2;
  localparam logic [NBR_CNT_W-1:0] SURVIVE_MAX = 4'd3;

  function automatic logic next_cell(input logic alive, input logic [NBR_CNT_W-1:0] cnt);
    if (alive) begin
      return (cnt >= SURVIVE_MIN) && (cnt <= SURVIVE_MAX);
    end
    return cnt == BIRTH_CNT;
  endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation logic for one row, given the rows above and below.
module life_row_next
  import life_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             wrap_i,
  input  logic [WIDTH-1:0] above_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] below_i,
  output logic [WIDTH-1:0] next_o
);

  // Bit 0 of each extended row is column -1 and bit WIDTH+1 is column WIDTH,
  // so column j sees its neighbourhood at extended bits j..j+2.
  logic [WIDTH+1:0] above_x;
  logic [WIDTH+1:0] cur_x;
  logic [WIDTH+1:0] below_x;
  logic [NBR_CNT_W-1:0] cnt;

  always_comb begin
    above_x = {wrap_i & above_i[0], above_i, wrap_i & above_i[WIDTH-1]};
    cur_x   = {wrap_i & cur_i[0],   cur_i,   wrap_i & cur_i[WIDTH-1]};
    below_x = {wrap_i & below_i[0], below_i, wrap_i & below_i[WIDTH-1]};
    next_o  = '0;
    cnt     = '0;
    for (int j = 0; j < WIDTH; j++) begin
      cnt = NBR_CNT_W'(above_x[j]) + NBR_CNT_W'(above_x[j+1]) + NBR_CNT_W'(above_x[j+2])
          + NBR_CNT_W'(cur_x[j])                               + NBR_CNT_W'(cur_x[j+2])
          + NBR_CNT_W'(below_x[j]) + NBR_CNT_W'(below_x[j+1]) + NBR_CNT_W'(below_x[j+2]);
      next_o[j] = next_cell(cur_x[j+1], cnt);
    end
  end

endmodule

// File: rtl/life_step.sv
// One Game of Life generation: streams the source grid through a three-row
// window and writes the next generation to a separate memory, one row per cycle.
module life_step
  import life_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ROWS       = 200,
  parameter int ADDR_WIDTH = 8,
  parameter int WRAP       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [WIDTH-1:0]      rd_data,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_en,
  output logic [WIDTH-1:0]      wr_data
);

  localparam int CNT_W = ADDR_WIDTH + 2;
  localparam logic [CNT_W-1:0]      LAST_K   = CNT_W'(ROWS + 1);
  localparam logic [CNT_W-1:0]      WRAP_K   = CNT_W'(ROWS);
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(2);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ROWS - 1);
  localparam logic                  WRAP_ON  = (WRAP != 0);

  state_e                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  issue_q, issue_d;
  logic [CNT_W-1:0]      issue_k_q, issue_k_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  ret_q, ret_d;
  logic                  ret_pad_q, ret_pad_d;
  logic [CNT_W-1:0]      ret_cnt_q, ret_cnt_d;
  logic [WIDTH-1:0]      win_above_q, win_above_d;
  logic [WIDTH-1:0]      win_cur_q, win_cur_d;
  logic [WIDTH-1:0]      win_below_q, win_below_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]      wr_data_q, wr_data_d;
  logic [WIDTH-1:0]      in_row;
  logic [WIDTH-1:0]      next_row;

  // Slots whose read was suppressed (off-grid rows without wrap) feed a dead row.
  assign in_row      = ret_pad_q ? '0 : rd_data;
  assign win_above_d = ret_q ? win_cur_q   : win_above_q;
  assign win_cur_d   = ret_q ? win_below_q : win_cur_q;
  assign win_below_d = ret_q ? in_row      : win_below_q;

  life_row_next #(
    .WIDTH(WIDTH)
  ) u_row_next (
    .wrap_i (WRAP_ON),
    .above_i(win_above_d),
    .cur_i  (win_cur_d),
    .below_i(win_below_d),
    .next_o (next_row)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    issue_d   = 1'b0;
    issue_k_d = issue_k_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    ret_d     = issue_q;
    ret_pad_d = ~rd_en_q;
    ret_cnt_d = ret_cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    // Every returned row after the first two completes a window centred on
    // row (returns - 2), which is written on the following cycle.
    if (ret_q) begin
      ret_cnt_d = ret_cnt_q + CNT_W'(1);
      if (ret_cnt_q >= FULL_CNT) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_WIDTH'(ret_cnt_q - FULL_CNT);
        wr_data_d = next_row;
      end
    end

    if (issue_q && (issue_k_q != LAST_K)) begin
      issue_d   = 1'b1;
      issue_k_d = issue_k_q + CNT_W'(1);
      rd_addr_d = (issue_k_q == WRAP_K) ? '0 : issue_k_q[ADDR_WIDTH-1:0];
      rd_en_d   = WRAP_ON || (issue_k_q != WRAP_K);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FILL;
          busy_d    = 1'b1;
          issue_d   = 1'b1;
          issue_k_d = '0;
          rd_addr_d = LAST_ROW;
          rd_en_d   = WRAP_ON;
          ret_cnt_d = '0;
        end
      end
      ST_FILL: begin
        if (ret_q && (ret_cnt_q == FULL_CNT)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wr_en_q && (wr_addr_q == LAST_ROW)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      issue_q     <= 1'b0;
      issue_k_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      ret_q       <= 1'b0;
      ret_pad_q   <= 1'b0;
      ret_cnt_q   <= '0;
      win_above_q <= '0;
      win_cur_q   <= '0;
      win_below_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      issue_q     <= issue_d;
      issue_k_q   <= issue_k_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      ret_q       <= ret_d;
      ret_pad_q   <= ret_pad_d;
      ret_cnt_q   <= ret_cnt_d;
      win_above_q <= win_above_d;
      win_cur_q   <= win_cur_d;
      win_below_q <= win_below_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_life_step.sv
// Scoreboard bench for life_step: a toroidal and a bounded instance run side by side.
module tb_life_step;

  localparam int WIDTH = 8;
  localparam int ROWS  = 8;
  localparam int AW    = 3;
  localparam int NEVER = 1000000;

  typedef struct {
    int         cyc;
    int         addr;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic mon_en = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic          busy1, done1, rd_en1, wr_en1;
  logic [AW-1:0] rd_addr1, wr_addr1;
  logic [7:0]    rd_data1, wr_data1;
  logic          busy0, done0, rd_en0, wr_en0;
  logic [AW-1:0] rd_addr0, wr_addr0;
  logic [7:0]    rd_data0, wr_data0;

  logic [7:0] src_mem [ROWS];
  logic [7:0] dst1 [ROWS];
  logic [7:0] dst0 [ROWS];
  logic [7:0] exp1 [ROWS];
  logic [7:0] exp0 [ROWS];

  ev_t wq1[$], wq0[$], rq1[$], rq0[$];
  int  dq1[$], dq0[$];

  always #5 clk = ~clk;

  life_step #(.WIDTH(WIDTH), .ROWS(ROWS), .ADDR_WIDTH(AW), .WRAP(1)) dut_w1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy1), .done(done1),
    .rd_addr(rd_addr1), .rd_en(rd_en1), .rd_data(rd_data1),
    .wr_addr(wr_addr1), .wr_en(wr_en1), .wr_data(wr_data1)
  );

  life_step #(.WIDTH(WIDTH), .ROWS(ROWS), .ADDR_WIDTH(AW), .WRAP(0)) dut_w0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy0), .done(done0),
    .rd_addr(rd_addr0), .rd_en(rd_en0), .rd_data(rd_data0),
    .wr_addr(wr_addr0), .wr_en(wr_en0), .wr_data(wr_data0)
  );

  // Source memories: one-cycle read latency, garbage on cycles without a read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_data1 <= rd_en1 ? src_mem[rd_addr1] : 8'($urandom);
    rd_data0 <= rd_en0 ? src_mem[rd_addr0] : 8'($urandom);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference next generation computed cell by cell for both boundary modes.
  task automatic model_gen();
    int n1, n0, rr, cc;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        n1 = 0;
        n0 = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
              n1 += int'(src_mem[(rr + ROWS) % ROWS][(cc + WIDTH) % WIDTH]);
              if (rr >= 0 && rr < ROWS && cc >= 0 && cc < WIDTH)
                n0 += int'(src_mem[rr][cc]);
            end
          end
        end
        exp1[r][c] = (n1 == 3) || (src_mem[r][c] && n1 == 2);
        exp0[r][c] = (n0 == 3) || (src_mem[r][c] && n0 == 2);
      end
    end
  endtask

  task automatic push_expected(input int s, input int last_cyc);
    ev_t e;
    model_gen();
    for (int k = 0; k <= ROWS + 1; k++) begin
      e.cyc  = s + 1 + k;
      e.addr = (k + ROWS - 1) % ROWS;
      e.data = '0;
      if (e.cyc <= last_cyc) begin
        rq1.push_back(e);
        if (k >= 1 && k <= ROWS) rq0.push_back(e);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      e.cyc  = s + 5 + r;
      e.addr = r;
      if (e.cyc <= last_cyc) begin
        e.data = exp1[r];
        wq1.push_back(e);
        e.data = exp0[r];
        wq0.push_back(e);
      end
    end
    if (s + 5 + ROWS <= last_cyc) begin
      dq1.push_back(s + 5 + ROWS);
      dq0.push_back(s + 5 + ROWS);
    end
  endtask

  // Every cycle, each strobe must match the scoreboard's schedule exactly.
  always @(negedge clk) begin
    logic exp_en;
    ev_t  ev;
    if (mon_en) begin
      exp_en = (rq1.size() > 0) && (rq1[0].cyc == cyc);
      check_val("rd_en_w1", 32'(rd_en1), 32'(exp_en));
      if (exp_en) begin
        ev = rq1.pop_front();
        if (rd_en1) check_val("rd_addr_w1", 32'(rd_addr1), 32'(ev.addr));
      end
      exp_en = (rq0.size() > 0) && (rq0[0].cyc == cyc);
      check_val("rd_en_w0", 32'(rd_en0), 32'(exp_en));
      if (exp_en) begin
        ev = rq0.pop_front();
        if (rd_en0) check_val("rd_addr_w0", 32'(rd_addr0), 32'(ev.addr));
      end
      exp_en = (wq1.size() > 0) && (wq1[0].cyc == cyc);
      check_val("wr_en_w1", 32'(wr_en1), 32'(exp_en));
      if (exp_en) begin
        ev = wq1.pop_front();
        if (wr_en1) begin
          check_val("wr_addr_w1", 32'(wr_addr1), 32'(ev.addr));
          check_val("wr_data_w1", 32'(wr_data1), 32'(ev.data));
        end
      end
      if (wr_en1) dst1[wr_addr1] = wr_data1;
      exp_en = (wq0.size() > 0) && (wq0[0].cyc == cyc);
      check_val("wr_en_w0", 32'(wr_en0), 32'(exp_en));
      if (exp_en) begin
        ev = wq0.pop_front();
        if (wr_en0) begin
          check_val("wr_addr_w0", 32'(wr_addr0), 32'(ev.addr));
          check_val("wr_data_w0", 32'(wr_data0), 32'(ev.data));
        end
      end
      if (wr_en0) dst0[wr_addr0] = wr_data0;
      exp_en = (dq1.size() > 0) && (dq1[0] == cyc);
      check_val("done_w1", 32'(done1), 32'(exp_en));
      if (exp_en) void'(dq1.pop_front());
      exp_en = (dq0.size() > 0) && (dq0[0] == cyc);
      check_val("done_w0", 32'(done0), 32'(exp_en));
      if (exp_en) void'(dq0.pop_front());
    end
  end

  task automatic check_output();
    check_val("wq1_left", 32'(wq1.size()), 32'd0);
    check_val("wq0_left", 32'(wq0.size()), 32'd0);
    check_val("rq1_left", 32'(rq1.size()), 32'd0);
    check_val("rq0_left", 32'(rq0.size()), 32'd0);
    check_val("dq1_left", 32'(dq1.size()), 32'd0);
    check_val("dq0_left", 32'(dq0.size()), 32'd0);
    wq1.delete(); wq0.delete(); rq1.delete(); rq0.delete(); dq1.delete(); dq0.delete();
  endtask

  task automatic clear_grids();
    for (int r = 0; r < ROWS; r++) begin
      src_mem[r] = 8'h00;
      dst1[r]    = 8'hAA;
      dst0[r]    = 8'hAA;
    end
  endtask

  task automatic apply_stimulus();
    int s;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    push_expected(s, NEVER);
    @(negedge clk);
    start = 1'b0;
    check_val("busy_first", 32'(busy1), 32'd1);
    while (cyc < s + 4 + ROWS) @(negedge clk);
    check_val("busy_last", 32'(busy1), 32'd1);
    @(negedge clk);
    check_val("busy_in_done", 32'(busy1), 32'd0);
    check_val("done_cycle", 32'(done1), 32'd1);
    @(negedge clk);
    check_val("done_cleared", 32'(done1), 32'd0);
    check_output();
  endtask

  initial begin
    int s;
    reset = 1'b1;
    start = 1'b1;
    clear_grids();
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(busy1), 32'd0);
    check_val("rst_done", 32'(done1), 32'd0);
    check_val("rst_rd_en", 32'(rd_en1), 32'd0);
    check_val("rst_wr_en", 32'(wr_en1), 32'd0);
    check_val("rst_rd_addr", 32'(rd_addr1), 32'd0);
    check_val("rst_wr_addr", 32'(wr_addr1), 32'd0);
    check_val("rst_wr_data", 32'(wr_data1), 32'd0);
    check_val("rst_busy_w0", 32'(busy0), 32'd0);
    start  = 1'b0;
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Vertical blinker becomes horizontal.
    clear_grids();
    src_mem[2] = 8'h08; src_mem[3] = 8'h08; src_mem[4] = 8'h08;
    apply_stimulus();
    check_val("blinker_row3", 32'(dst1[3]), 32'h1C);
    check_val("blinker_row2", 32'(dst1[2]), 32'h00);
    check_val("blinker_row4", 32'(dst1[4]), 32'h00);

    // Still-life block.
    clear_grids();
    src_mem[0] = 8'h18; src_mem[1] = 8'h18;
    apply_stimulus();
    check_val("block_row0", 32'(dst1[0]), 32'h18);
    check_val("block_row1", 32'(dst1[1]), 32'h18);

    // Corner cells meet only across the wrapped edges.
    clear_grids();
    src_mem[7] = 8'h01; src_mem[0] = 8'h81;
    apply_stimulus();
    check_val("wrap_row0", 32'(dst1[0]), 32'h81);
    check_val("wrap_row7", 32'(dst1[7]), 32'h81);
    check_val("nowrap_row0", 32'(dst0[0]), 32'h00);
    check_val("nowrap_row7", 32'(dst0[7]), 32'h00);

    clear_grids();
    apply_stimulus();
    check_val("zero_row5", 32'(dst1[5]), 32'h00);

    for (int t = 0; t < 3; t++) begin
      clear_grids();
      for (int r = 0; r < ROWS; r++) src_mem[r] = 8'($urandom);
      apply_stimulus();
    end

    // Reset in the middle of a step aborts it.
    clear_grids();
    src_mem[2] = 8'h08; src_mem[3] = 8'h08; src_mem[4] = 8'h08;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    push_expected(s, s + 7);
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("abort_busy", 32'(busy1), 32'd0);
    check_val("abort_busy_w0", 32'(busy0), 32'd0);
    repeat (ROWS + 4) @(negedge clk);
    check_val("abort_row3_unwritten", 32'(dst1[3]), 32'hAA);
    check_output();
    apply_stimulus();

    // Start held high: one step, then a second beginning right after done.
    clear_grids();
    for (int r = 0; r < ROWS; r++) src_mem[r] = 8'($urandom);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    push_expected(s, NEVER);
    push_expected(s + ROWS + 6, NEVER);
    while (cyc < s + ROWS + 7) @(negedge clk);
    start = 1'b0;
    check_val("hold_second_busy", 32'(busy1), 32'd1);
    while (cyc < s + 2 * ROWS + 14) @(negedge clk);
    check_output();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
